// File: rtl/bht_pkg.sv
// Shared constants, index type and saturating-step helper for the branch history table.
package bht_pkg;

    localparam int CTR_WIDTH_DEF   = 2;
    localparam int INDEX_BITS_DEF  = 6;
    localparam int PC_WIDTH_DEF    = 32;
    localparam int RESET_VALUE_DEF = 1;
    localparam int CTR_MAX_WIDTH   = 16;

    typedef logic [INDEX_BITS_DEF-1:0] bht_idx_t;
    typedef logic [CTR_MAX_WIDTH-1:0]  ctr_max_t;

    // Saturation is decided against all-ones/all-zeros of the live width before stepping,
    // so the counter never wraps regardless of how wide the carrier type is.
    function automatic ctr_max_t sat_step(input ctr_max_t ctr, input logic taken, input int width);
        ctr_max_t ones;
        ones = '0;
        for (int i = 0; i < CTR_MAX_WIDTH; i++) begin
            ones[i] = (i < width);
        end
        if (taken) begin
            return (ctr == ones) ? ctr : ctr + ctr_max_t'(1);
        end
        return (ctr == '0) ? ctr : ctr - ctr_max_t'(1);
    endfunction

endpackage

// File: rtl/bht_sat_ctr.sv
// One WIDTH-bit saturating up/down counter; generalisation of the classic 2-bit predictor counter.
module bht_sat_ctr
    import bht_pkg::*;
#(
    parameter int               WIDTH       = CTR_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(RESET_VALUE_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] ctr_o
);

    logic [WIDTH-1:0] ctr_q, ctr_d;

    always_comb begin
        // NOTE: default first so every path assigns ctr_d; otherwise a latch is inferred.
        ctr_d = ctr_q;
        if (inc_i) begin
            ctr_d = WIDTH'(sat_step(ctr_max_t'(ctr_q), 1'b1, WIDTH));
        end else if (dec_i) begin
            ctr_d = WIDTH'(sat_step(ctr_max_t'(ctr_q), 1'b0, WIDTH));
        end
    end

    // NOTE: non-blocking assignment for state so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q <= RESET_VALUE;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/bht_predictor.sv
// Branch history table of saturating counters with 1-cycle lookup and write-first bypass.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module bht_predictor
    import bht_pkg::*;
#(
    parameter int CTR_WIDTH   = CTR_WIDTH_DEF,
    parameter int INDEX_BITS  = INDEX_BITS_DEF,
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int RESET_VALUE = RESET_VALUE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_valid,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [CTR_WIDTH-1:0]  pred_ctr,
`ifdef BHT_GSHARE_EN
    output logic [INDEX_BITS-1:0] pred_hist,
    input  logic [INDEX_BITS-1:0] update_hist,
`endif
    input  logic                  update_valid,
    input  logic [PC_WIDTH-1:0]   update_pc,
    input  logic                  update_taken
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0] lookup_idx, update_idx;
    logic [CTR_WIDTH-1:0]  ctr_tbl [ENTRIES];
    logic [CTR_WIDTH-1:0]  rd_ctr, lookup_ctr;
    logic                  pred_valid_q, pred_valid_d;
    logic [CTR_WIDTH-1:0]  pred_ctr_q, pred_ctr_d;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0],
                              update_pc[PC_WIDTH-1:INDEX_BITS+2], update_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q, ghr_d;
    logic [INDEX_BITS-1:0] pred_hist_q, pred_hist_d;

    assign lookup_idx = lookup_pc[INDEX_BITS+1:2] ^ ghr_q;
    assign update_idx = update_pc[INDEX_BITS+1:2] ^ update_hist;

    // History advances only on resolved outcomes; lookups this cycle still see the old value.
    always_comb begin
        ghr_d       = ghr_q;
        pred_hist_d = pred_hist_q;
        if (update_valid) begin
            ghr_d = {ghr_q[INDEX_BITS-2:0], update_taken};
        end
        if (lookup_valid) begin
            pred_hist_d = ghr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q       <= '0;
            pred_hist_q <= '0;
        end else begin
            ghr_q       <= ghr_d;
            pred_hist_q <= pred_hist_d;
        end
    end

    assign pred_hist = pred_hist_q;
`else
    assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
    assign update_idx = update_pc[INDEX_BITS+1:2];
`endif

    // NOTE: the whole table is flops and each entry resets itself, so reset completes in one cycle.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic hit;
        assign hit = update_valid && (update_idx == INDEX_BITS'(i));
        bht_sat_ctr #(
            .WIDTH       (CTR_WIDTH),
            .RESET_VALUE (CTR_WIDTH'(RESET_VALUE))
        ) u_ctr (
            .clk   (clk),
            .reset (reset),
            .inc_i (hit & update_taken),
            .dec_i (hit & ~update_taken),
            .ctr_o (ctr_tbl[i])
        );
    end

    assign rd_ctr = ctr_tbl[lookup_idx];

    // Write-first: a same-cycle update to the looked-up entry is visible in the prediction.
    always_comb begin
        lookup_ctr = rd_ctr;
        if (update_valid && (update_idx == lookup_idx)) begin
            lookup_ctr = CTR_WIDTH'(sat_step(ctr_max_t'(rd_ctr), update_taken, CTR_WIDTH));
        end
    end

    always_comb begin
        pred_valid_d = lookup_valid;
        pred_ctr_d   = pred_ctr_q;
        if (lookup_valid) begin
            pred_ctr_d = lookup_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_ctr_q   <= pred_ctr_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_ctr   = pred_ctr_q;
    assign pred_taken = pred_ctr_q[CTR_WIDTH-1];

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed scenarios plus randomized traffic vs. an array model.
// Exercises the gshare path too when BHT_GSHARE_EN is defined.
module tb_bht_predictor;

    localparam int CW = 2;
    localparam int IB = 6;
    localparam int PW = 32;
    localparam int RV = 1;
    localparam int ENT = 1 << IB;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          lookup_valid;
    logic [PW-1:0] lookup_pc;
    logic          update_valid;
    logic [PW-1:0] update_pc;
    logic          update_taken;
    logic          pred_valid;
    logic          pred_taken;
    logic [CW-1:0] pred_ctr;
`ifdef BHT_GSHARE_EN
    logic [IB-1:0] pred_hist;
    logic [IB-1:0] update_hist;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned m_tbl [ENT];
    int unsigned m_ghr;
    int unsigned e_ctr;
    int unsigned e_hist;
    bit          e_valid;

    bht_predictor #(
        .CTR_WIDTH   (CW),
        .INDEX_BITS  (IB),
        .PC_WIDTH    (PW),
        .RESET_VALUE (RV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_ctr     (pred_ctr),
`ifdef BHT_GSHARE_EN
        .pred_hist    (pred_hist),
        .update_hist  (update_hist),
`endif
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .update_taken (update_taken)
    );

    always #5 clk = ~clk;

    function automatic int unsigned base_idx(input logic [PW-1:0] pc);
        return (pc >> 2) % ENT;
    endfunction

    // Reset cycle with random (ignored) request inputs.
    task automatic do_reset();
        reset        = 1'b1;
        lookup_valid = 1'($urandom);
        lookup_pc    = $urandom;
        update_valid = 1'($urandom);
        update_pc    = $urandom;
        update_taken = 1'($urandom);
`ifdef BHT_GSHARE_EN
        update_hist  = IB'($urandom);
`endif
        foreach (m_tbl[i]) m_tbl[i] = RV;
        m_ghr   = 0;
        e_valid = 0;
        e_ctr   = 0;
        e_hist  = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One cycle of traffic; the model applies the update then reads, giving write-first semantics.
    task automatic step(input bit lv, input logic [PW-1:0] lpc, input bit uv,
                        input logic [PW-1:0] upc, input bit ut, input int unsigned uh);
        int unsigned li, ui;
        reset        = 1'b0;
        lookup_valid = lv;
        lookup_pc    = lpc;
        update_valid = uv;
        update_pc    = upc;
        update_taken = ut;
        li = base_idx(lpc);
        ui = base_idx(upc);
`ifdef BHT_GSHARE_EN
        update_hist = IB'(uh);
        li = li ^ m_ghr;
        ui = ui ^ (uh % ENT);
`endif
        if (uv) begin
            if (ut) m_tbl[ui] = (m_tbl[ui] == CMAX) ? CMAX : m_tbl[ui] + 1;
            else    m_tbl[ui] = (m_tbl[ui] == 0) ? 0 : m_tbl[ui] - 1;
        end
        if (lv) begin
            e_ctr  = m_tbl[li];
            e_hist = m_ghr;
        end
        e_valid = lv;
`ifdef BHT_GSHARE_EN
        if (uv) m_ghr = ((m_ghr << 1) | 32'(ut)) % ENT;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (pred_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %0b want 0", pred_valid);
        end
        n_cmp++;
        if (pred_ctr !== '0 || pred_taken !== 1'b0) begin
            n_bad++; $display("FAIL reset_ctr: got ctr %0d taken %0b want 0/0", pred_ctr, pred_taken);
        end
    endtask

    task automatic test_basic_lookup();
        step(1, 32'h0, 0, 32'h0, 0, 0);
        n_cmp++;
        if (pred_valid !== 1'b1 || pred_ctr !== CW'(RV) || pred_taken !== 1'b0) begin
            n_bad++; $display("FAIL basic_lookup: got v%0b ctr %0d t%0b want v1 ctr %0d t0",
                              pred_valid, pred_ctr, pred_taken, RV);
        end
        step(0, 32'h0, 0, 32'h0, 0, 0);
        n_cmp++;
        if (pred_valid !== 1'b0 || pred_ctr !== CW'(e_ctr)) begin
            n_bad++; $display("FAIL idle_hold: got v%0b ctr %0d want v0 ctr %0d", pred_valid, pred_ctr, e_ctr);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            step(0, 32'h0, 1, 32'h40, 1, 0);
            step(1, 32'h40, 0, 32'h0, 0, 0);
            n_cmp++;
            if (pred_ctr !== CW'(e_ctr) || pred_taken !== e_ctr[CW-1]) begin
                n_bad++; $display("FAIL sat_high[%0d]: got ctr %0d t%0b want %0d", i, pred_ctr, pred_taken, e_ctr);
            end
        end
`ifndef BHT_GSHARE_EN
        n_cmp++;
        if (pred_ctr !== CW'(CMAX)) begin
            n_bad++; $display("FAIL sat_high_abs: got %0d want %0d", pred_ctr, CMAX);
        end
`endif
        for (int i = 0; i < 5; i++) begin
            step(0, 32'h0, 1, 32'h40, 0, 0);
            step(1, 32'h40, 0, 32'h0, 0, 0);
            n_cmp++;
            if (pred_ctr !== CW'(e_ctr) || pred_taken !== e_ctr[CW-1]) begin
                n_bad++; $display("FAIL sat_low[%0d]: got ctr %0d t%0b want %0d", i, pred_ctr, pred_taken, e_ctr);
            end
        end
`ifndef BHT_GSHARE_EN
        n_cmp++;
        if (pred_ctr !== '0) begin
            n_bad++; $display("FAIL sat_low_abs: got %0d want 0", pred_ctr);
        end
`endif
    endtask

    task automatic test_bypass();
        do_reset();
        step(1, 32'h08, 1, 32'h08, 1, 0);
        n_cmp++;
        if (pred_valid !== 1'b1 || pred_ctr !== CW'(e_ctr)) begin
            n_bad++; $display("FAIL bypass: got v%0b ctr %0d want v1 ctr %0d", pred_valid, pred_ctr, e_ctr);
        end
`ifndef BHT_GSHARE_EN
        n_cmp++;
        if (pred_ctr !== 2'd2) begin
            n_bad++; $display("FAIL bypass_abs: got %0d want 2", pred_ctr);
        end
`endif
        step(1, 32'h108, 0, 32'h0, 0, 0);
        n_cmp++;
        if (pred_ctr !== CW'(e_ctr)) begin
            n_bad++; $display("FAIL alias: got %0d want %0d", pred_ctr, e_ctr);
        end
        step(1, 32'h0C, 1, 32'h20, 1, 0);
        n_cmp++;
        if (pred_ctr !== CW'(e_ctr)) begin
            n_bad++; $display("FAIL diff_index: got %0d want %0d", pred_ctr, e_ctr);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(0, 32'h0, 1, 32'h24, 1, 0);
        step(0, 32'h0, 1, 32'h24, 1, 0);
        step(1, 32'h24, 1, 32'h24, 0, 0);
        n_cmp++;
        if (pred_ctr !== CW'(e_ctr)) begin
            n_bad++; $display("FAIL back_to_back: got %0d want %0d", pred_ctr, e_ctr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 32'h10, 1, 0);
        step(1, 32'h10, 0, 32'h0, 0, 0);
        reset        = 1'b1;
        lookup_valid = 1'b1;
        lookup_pc    = 32'h10;
        update_valid = 1'b1;
        update_pc    = 32'h10;
        update_taken = 1'b1;
        foreach (m_tbl[i]) m_tbl[i] = RV;
        m_ghr = 0;
        e_ctr = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (pred_valid !== 1'b0 || pred_ctr !== '0) begin
            n_bad++; $display("FAIL reset_mid: got v%0b ctr %0d want v0 ctr 0", pred_valid, pred_ctr);
        end
        step(1, 32'h10, 0, 32'h0, 0, 0);
        n_cmp++;
        if (pred_valid !== 1'b1 || pred_ctr !== CW'(RV)) begin
            n_bad++; $display("FAIL post_reset: got v%0b ctr %0d want v1 ctr %0d", pred_valid, pred_ctr, RV);
        end
    endtask

`ifdef BHT_GSHARE_EN
    task automatic test_gshare();
        do_reset();
        step(0, 32'h0, 1, 32'h40, 1, 0);
        step(0, 32'h0, 1, 32'h40, 1, 0);
        step(0, 32'h0, 1, 32'h40, 0, 0);
        step(1, 32'h0C, 0, 32'h0, 0, 0);
        n_cmp++;
        if (pred_hist !== 6'b000110 || pred_ctr !== CW'(e_ctr)) begin
            n_bad++; $display("FAIL gshare: got hist %0d ctr %0d want hist 6 ctr %0d", pred_hist, pred_ctr, e_ctr);
        end
    endtask
`endif

    task automatic test_random();
        logic [PW-1:0] lpc, upc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            lpc = $urandom;
            upc = $urandom_range(0, 3) == 0 ? lpc : {$urandom} & 32'h0000_00FC;
            step(1'($urandom_range(0, 3) != 0), lpc, 1'($urandom_range(0, 2) != 0), upc,
                 1'($urandom), $urandom % ENT);
            n_cmp++;
            if (pred_valid !== e_valid || pred_ctr !== CW'(e_ctr) || pred_taken !== e_ctr[CW-1]) begin
                n_bad++; $display("FAIL random[%0d]: got v%0b ctr %0d t%0b want v%0b ctr %0d",
                                  i, pred_valid, pred_ctr, pred_taken, e_valid, e_ctr);
            end
`ifdef BHT_GSHARE_EN
            n_cmp++;
            if (pred_hist !== IB'(e_hist)) begin
                n_bad++; $display("FAIL random_hist[%0d]: got %0d want %0d", i, pred_hist, e_hist);
            end
`endif
        end
    endtask

    initial begin
        reset        = 1'b1;
        lookup_valid = 1'b0;
        lookup_pc    = '0;
        update_valid = 1'b0;
        update_pc    = '0;
        update_taken = 1'b0;
`ifdef BHT_GSHARE_EN
        update_hist  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic_lookup();
        test_saturation();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
`ifdef BHT_GSHARE_EN
        test_gshare();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
